// File: rtl/adc_snap_capture_pkg.sv
// adc_snap_capture_pkg
//   Shared definitions for the ADC snapshot capture block:
//   - clog2b(): ceiling log2 used to size address fields
//   - snap_state_e: FSM state encoding exposed on snap_state
//   - default geometry constants (DEPTH / LANES / CH_NUM)
package adc_snap_capture_pkg;

  function automatic int clog2b(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  typedef enum logic [2:0] {
    SNAP_IDLE = 3'd0,
    SNAP_PRE  = 3'd1,
    SNAP_WAIT = 3'd2,
    SNAP_POST = 3'd3,
    SNAP_DONE = 3'd4
  } snap_state_e;

  localparam int SNAP_DEF_DEPTH  = 512;
  localparam int SNAP_DEF_LANES  = 4;
  localparam int SNAP_DEF_CH_NUM = 4;

endpackage

// File: rtl/adc_snap_capture_if.sv
// adc_snap_capture_if
//   Register-block side of the snapshot buffer.
//   Ports (signals):
//     adc_snap_addr       sample read address (bus master drives)
//     adc_snap_data       read sample (capture block drives)
//     snap_capture_ready  capture window complete (capture block drives)
//   Handshake: there is no valid/ready pair on this bus. A read is
//   issued by placing an address on adc_snap_addr; the matching sample
//   appears on adc_snap_data exactly 2 clk later, one new address may be
//   presented every clk. snap_capture_ready is a level that stays high
//   from the end of a capture until the next arm or reset; the data is
//   only a stable snapshot while it is high.
interface adc_snap_capture_if #(
  parameter int ADC_DATA_WIDTH     = 8,
  parameter int ARM_BUS_DATA_WIDTH = 16
);
  logic [ARM_BUS_DATA_WIDTH-1:0] adc_snap_addr;
  logic [ADC_DATA_WIDTH-1:0]     adc_snap_data;
  logic                          snap_capture_ready;

  modport master (
    output adc_snap_addr,
    input  adc_snap_data,
    input  snap_capture_ready
  );

  modport slave (
    input  adc_snap_addr,
    output adc_snap_data,
    output snap_capture_ready
  );
endinterface

// File: rtl/adc_snap_capture_sdp_ram.sv
// adc_snap_capture_sdp_ram
//   Simple dual-port single-clock RAM for the capture window.
//   Ports:
//     clk, srst  clock / sync active-high reset (read register only)
//     we, waddr, wdata  write port
//     raddr, rdata      read port, registered output (1 clk latency)
//   Memory contents are never reset so the array maps to block RAM.
module adc_snap_capture_sdp_ram
  import adc_snap_capture_pkg::*;
#(
  parameter int WIDTH = 128,
  parameter int DEPTH = SNAP_DEF_DEPTH,
  localparam int ADDR_WIDTH = clog2b(DEPTH)
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (srst) rdata <= '0;
    else      rdata <= mem[raddr];
  end

endmodule

// File: rtl/adc_snap_capture.sv
// adc_snap_capture
//   Captures a DEPTH-word window of CH_NUM x LANES ADC samples around a
//   trigger into a circular RAM, with a programmable pre-trigger length.
//   Ports:
//     clk, srst      single clock, sync active-high reset
//     adc_din        {ch[CH_NUM-1]..ch0}, each {lane[LANES-1]..lane0}
//     snap_arm       1-clk pulse, starts/restarts a capture
//     snap_trig      external trigger, level sampled
//     pre_trig_len   words kept before the trigger word, latched on arm
//     bus            read bus (address / sample / ready), slave side
//     snap_state     FSM state (snap_state_e encoding)
//     trig_ptr       physical RAM address of the trigger word
//   Optional build macro SNAP_LEVEL_TRIG_EN adds trig_level / trig_sel:
//   a level trigger on |ch0 sample| > trig_level, with the data path
//   delayed one extra stage to keep trigger/word alignment.
module adc_snap_capture
  import adc_snap_capture_pkg::*;
#(
  parameter int ADC_DATA_WIDTH     = 8,
  parameter int LANES              = SNAP_DEF_LANES,
  parameter int CH_NUM             = SNAP_DEF_CH_NUM,
  parameter int DEPTH              = SNAP_DEF_DEPTH,
  parameter int ARM_BUS_DATA_WIDTH = 16,
  localparam int WADDR_WIDTH       = clog2b(DEPTH)
) (
  input  logic                                    clk,
  input  logic                                    srst,
  input  logic [CH_NUM*LANES*ADC_DATA_WIDTH-1:0]  adc_din,
  input  logic                                    snap_arm,
  input  logic                                    snap_trig,
  input  logic [WADDR_WIDTH-1:0]                  pre_trig_len,
`ifdef SNAP_LEVEL_TRIG_EN
  input  logic [ADC_DATA_WIDTH-1:0]               trig_level,
  input  logic                                    trig_sel,
`endif
  adc_snap_capture_if.slave                       bus,
  output logic [2:0]                              snap_state,
  output logic [WADDR_WIDTH-1:0]                  trig_ptr
);

  localparam int CH_W          = clog2b(CH_NUM);
  localparam int LANE_W        = clog2b(LANES);
  localparam int SEL_W         = CH_W + LANE_W;
  localparam int RD_ADDR_WIDTH = WADDR_WIDTH + SEL_W;
  localparam int WORD_W        = CH_NUM * LANES * ADC_DATA_WIDTH;

  // ---------------- input pipeline ----------------
  logic [WORD_W-1:0] din_q;
  logic              trig_q;
  logic [WORD_W-1:0] wr_data;
  logic              trig_src;

  always_ff @(posedge clk) begin
    if (srst) begin
      din_q  <= '0;
      trig_q <= 1'b0;
    end else begin
      din_q  <= adc_din;
      trig_q <= snap_trig;
    end
  end

`ifdef SNAP_LEVEL_TRIG_EN
  logic [WORD_W-1:0] din_d2;
  logic              trig_d2;
  logic              lvl_q;
  logic              lvl_hit;

  function automatic logic mag_gt(input logic [ADC_DATA_WIDTH-1:0] s,
                                  input logic [ADC_DATA_WIDTH-1:0] lvl);
    logic [ADC_DATA_WIDTH:0] mag;
    // One extra bit so that the most negative code (-2^(N-1)) has a
    // representable magnitude.
    mag = s[ADC_DATA_WIDTH-1] ? ({1'b0, ~s} + {{ADC_DATA_WIDTH{1'b0}}, 1'b1})
                              : {1'b0, s};
    return mag > {1'b0, lvl};
  endfunction

  always_comb begin
    lvl_hit = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      if (mag_gt(din_q[l*ADC_DATA_WIDTH +: ADC_DATA_WIDTH], trig_level))
        lvl_hit = 1'b1;
    end
  end

  // Data and external trigger take the same extra stage as the level
  // detector so every trigger source lines up with its own word.
  always_ff @(posedge clk) begin
    if (srst) begin
      din_d2  <= '0;
      trig_d2 <= 1'b0;
      lvl_q   <= 1'b0;
    end else begin
      din_d2  <= din_q;
      trig_d2 <= trig_q;
      lvl_q   <= lvl_hit;
    end
  end

  assign wr_data  = din_d2;
  assign trig_src = trig_sel ? lvl_q : trig_d2;
`else
  assign wr_data  = din_q;
  assign trig_src = trig_q;
`endif

  // ---------------- capture FSM ----------------
  snap_state_e             state, state_nx;
  logic [WADDR_WIDTH-1:0]  wr_ptr, pre_cnt, pre_len, post_cnt;
  logic [WADDR_WIDTH-1:0]  post_len;
  logic                    wr_en;

  // DEPTH-1-pre_len; DEPTH is a power of two so this is a bit inversion.
  assign post_len = ~pre_len;

  always_ff @(posedge clk) begin
    if (srst) state <= SNAP_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (snap_arm) begin
      state_nx = SNAP_PRE;
    end else begin
      case (state)
        SNAP_PRE:  if (pre_cnt == pre_len) state_nx = SNAP_WAIT;
        SNAP_WAIT: if (trig_src) state_nx = (post_len == '0) ? SNAP_DONE : SNAP_POST;
        SNAP_POST: if (post_cnt == WADDR_WIDTH'(1)) state_nx = SNAP_DONE;
        default:   ;
      endcase
    end
  end

  always_comb begin
    wr_en = 1'b0;
    case (state)
      SNAP_PRE, SNAP_WAIT, SNAP_POST: wr_en = !snap_arm;
      default: ;
    endcase
    bus.snap_capture_ready = (state == SNAP_DONE);
    snap_state             = state;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr   <= '0;
      pre_cnt  <= '0;
      pre_len  <= '0;
      post_cnt <= '0;
      trig_ptr <= '0;
    end else if (snap_arm) begin
      pre_len <= pre_trig_len;
      wr_ptr  <= '0;
      pre_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + WADDR_WIDTH'(1);
      if (state == SNAP_PRE) pre_cnt <= pre_cnt + WADDR_WIDTH'(1);
      if (state == SNAP_WAIT && trig_src) begin
        trig_ptr <= wr_ptr;
        post_cnt <= post_len;
      end
      if (state == SNAP_POST) post_cnt <= post_cnt - WADDR_WIDTH'(1);
    end
  end

  // ---------------- read path ----------------
  logic [RD_ADDR_WIDTH-1:0] rd_addr;
  logic [WADDR_WIDTH-1:0]   rd_word, rd_phys_q;
  logic [SEL_W-1:0]         rd_sel, sel_q, sel_q2;
  logic [WORD_W-1:0]        ram_q;
  logic [ADC_DATA_WIDTH-1:0] rd_samples [CH_NUM*LANES];

  assign rd_addr = bus.adc_snap_addr[RD_ADDR_WIDTH-1:0];
  assign rd_word = rd_addr[RD_ADDR_WIDTH-1 -: WADDR_WIDTH];
  assign rd_sel  = rd_addr[SEL_W-1:0];

  generate
    if (ARM_BUS_DATA_WIDTH > RD_ADDR_WIDTH) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^bus.adc_snap_addr[ARM_BUS_DATA_WIDTH-1:RD_ADDR_WIDTH];
    end
  endgenerate

  // Logical word -> physical word: rebase on the window start
  // (trig_ptr - pre_len), wrapping naturally in WADDR_WIDTH bits.
  always_ff @(posedge clk) begin
    if (srst) begin
      rd_phys_q <= '0;
      sel_q     <= '0;
      sel_q2    <= '0;
    end else begin
      rd_phys_q <= rd_word + trig_ptr - pre_len;
      sel_q     <= rd_sel;
      sel_q2    <= sel_q;
    end
  end

  adc_snap_capture_sdp_ram #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .srst  (srst),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_phys_q),
    .rdata (ram_q)
  );

  // {ch, lane} is directly the sample index because both are powers of two.
  always_comb begin
    for (int i = 0; i < CH_NUM*LANES; i++)
      rd_samples[i] = ram_q[i*ADC_DATA_WIDTH +: ADC_DATA_WIDTH];
  end

  assign bus.adc_snap_data = rd_samples[sel_q2];

endmodule

// File: tb/tb_adc_snap_capture.sv
// tb_adc_snap_capture
//   Directed/randomised bench for adc_snap_capture at default parameters.
//   The reference model keeps the full stream of driven words; the
//   captured window is the DEPTH consecutive words starting pre_len words
//   before the word driven together with the trigger.
module tb_adc_snap_capture;

  localparam int DEPTH = 512;
  localparam int WW    = 128;
`ifdef SNAP_LEVEL_TRIG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic           clk = 1'b0;
  logic           srst;
  logic [WW-1:0]  adc_din;
  logic           snap_arm;
  logic           snap_trig;
  logic [8:0]     pre_trig_len;
  logic [2:0]     snap_state;
  logic [8:0]     trig_ptr;
`ifdef SNAP_LEVEL_TRIG_EN
  logic [7:0]     trig_level;
  logic           trig_sel;
`endif

  adc_snap_capture_if #(.ADC_DATA_WIDTH(8), .ARM_BUS_DATA_WIDTH(16)) bif ();

  adc_snap_capture dut (
    .clk          (clk),
    .srst         (srst),
    .adc_din      (adc_din),
    .snap_arm     (snap_arm),
    .snap_trig    (snap_trig),
    .pre_trig_len (pre_trig_len),
`ifdef SNAP_LEVEL_TRIG_EN
    .trig_level   (trig_level),
    .trig_sel     (trig_sel),
`endif
    .bus          (bif),
    .snap_state   (snap_state),
    .trig_ptr     (trig_ptr)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model / scoreboard state ----------------
  logic [WW-1:0] hist[$];
  int            n_cmp = 0;
  int            n_err = 0;
  bit            ramp_mode;
  bit            use_fixed;
  logic [WW-1:0] fixed_word;
  int            arm_cyc, trig_cyc, plen, old_ptr;

  function automatic logic [WW-1:0] ramp_word(input int n);
    logic [WW-1:0] w;
    w = '0;
    for (int c = 0; c < 4; c++)
      for (int l = 0; l < 4; l++)
        w[(c*4+l)*8 +: 8] = 8'((n*16 + c*4 + l) % 256);
    return w;
  endfunction

  function automatic logic [7:0] exp_sample(input int w, input int ch, input int ln);
    logic [WW-1:0] wd;
    wd = hist[trig_cyc - plen + w];
    return wd[(ch*4+ln)*8 +: 8];
  endfunction

  function automatic logic [8:0] exp_ptr();
    return 9'((trig_cyc - (arm_cyc + 1 - LAT)) % DEPTH);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    if (use_fixed)      adc_din = fixed_word;
    else if (ramp_mode) adc_din = ramp_word(hist.size());
    else                adc_din = {$urandom, $urandom, $urandom, $urandom};
    hist.push_back(adc_din);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic arm(input int len);
    pre_trig_len = 9'(len);
    snap_arm = 1'b1;
    arm_cyc = hist.size();
    tick();
    snap_arm = 1'b0;
    plen = len;
  endtask

  task automatic trig();
    snap_trig = 1'b1;
    trig_cyc = hist.size();
    tick();
    snap_trig = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!bif.snap_capture_ready && n < 2*DEPTH) begin
      tick();
      n++;
    end
    chk(tag, WW'(n), WW'(LAT + DEPTH - 1 - plen));
  endtask

  task automatic read_chk(input string tag, input int w, input int ch, input int ln);
    bif.adc_snap_addr = 16'(w*16 + ch*4 + ln);
    tick();
    tick();
    chk(tag, WW'(bif.adc_snap_data), WW'(exp_sample(w, ch, ln)));
  endtask

  task automatic rand_reads(input string tag, input int n);
    for (int i = 0; i < n; i++)
      read_chk(tag, $urandom_range(0, DEPTH-1), $urandom_range(0, 3), $urandom_range(0, 3));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    srst = 1'b1;
    snap_arm = 1'b0;
    snap_trig = 1'b0;
    pre_trig_len = '0;
    bif.adc_snap_addr = '0;
    ramp_mode = 1'b1;
    use_fixed = 1'b0;
    fixed_word = '0;
`ifdef SNAP_LEVEL_TRIG_EN
    trig_level = 8'd100;
    trig_sel = 1'b0;
`endif

    // reset state
    repeat (3) tick();
    chk("rst_state", WW'(snap_state), WW'(0));
    chk("rst_ready", WW'(bif.snap_capture_ready), WW'(0));
    chk("rst_trig_ptr", WW'(trig_ptr), WW'(0));
    chk("rst_data", WW'(bif.adc_snap_data), WW'(0));
    srst = 1'b0;
    tick();

    // ramp, pre 100, trigger 300 clk after arm
    arm(100);
    chk("a_state_pre", WW'(snap_state), WW'(1));
    repeat (299) tick();
    chk("a_state_wait", WW'(snap_state), WW'(2));
    trig();
    wait_ready("a_ready_lat");
    chk("a_state_done", WW'(snap_state), WW'(4));
    chk("a_trig_ptr", WW'(trig_ptr), WW'(exp_ptr()));
    read_chk("a_trig_word", 100, 0, 0);
    chk("a_trig_ramp", WW'(bif.adc_snap_data), WW'(8'((trig_cyc*16) % 256)));
    rand_reads("a_rand_rd", 6);

    // random data, pre 0, trigger on first WAIT cycle
    ramp_mode = 1'b0;
    arm(0);
    trig();
    wait_ready("b_ready_lat");
    chk("b_trig_ptr", WW'(trig_ptr), WW'(exp_ptr()));
    read_chk("b_logical0", 0, $urandom_range(0, 3), $urandom_range(0, 3));
    read_chk("b_logical511", 511, $urandom_range(0, 3), $urandom_range(0, 3));
    rand_reads("b_rand_rd", 4);

    // pre 511: trigger write is the last write
    arm(511);
    repeat (511) tick();
    trig();
    wait_ready("c_ready_lat");
    chk("c_trig_ptr", WW'(trig_ptr), WW'(exp_ptr()));
    read_chk("c_logical511", 511, $urandom_range(0, 3), $urandom_range(0, 3));
    read_chk("c_logical0", 0, $urandom_range(0, 3), $urandom_range(0, 3));

    // trigger in PRE is ignored
    arm(50);
    repeat (19) tick();
    trig();
    repeat (10) tick();
    chk("d_pre_ignore_state", WW'(snap_state), WW'(1));
    repeat (40) tick();
    chk("d_wait_state", WW'(snap_state), WW'(2));
    chk("d_ready_low", WW'(bif.snap_capture_ready), WW'(0));
    trig();
    wait_ready("d_ready_lat");
    chk("d_trig_ptr", WW'(trig_ptr), WW'(exp_ptr()));
    rand_reads("d_rand_rd", 3);

    // arm during POST restarts
    arm(30);
    repeat (39) tick();
    trig();
    repeat (20) tick();
    chk("e_post_state", WW'(snap_state), WW'(3));
    old_ptr = int'(exp_ptr());
    chk("e_old_ptr", WW'(trig_ptr), WW'(old_ptr));
    arm(30);
    chk("e_rearm_state", WW'(snap_state), WW'(1));
    chk("e_rearm_ready", WW'(bif.snap_capture_ready), WW'(0));
    repeat (35) tick();
    chk("e_wait_state", WW'(snap_state), WW'(2));
    chk("e_ptr_held", WW'(trig_ptr), WW'(old_ptr));
    repeat (24) tick();
    trig();
    wait_ready("e_ready_lat");
    chk("e_new_ptr", WW'(trig_ptr), WW'(exp_ptr()));
    rand_reads("e_rand_rd", 3);

    // trigger and arm reach the FSM on the same edge: arm wins
    arm(5);
    repeat (10) tick();
    chk("f_wait_state", WW'(snap_state), WW'(2));
    snap_trig = 1'b1;
    tick();
    snap_trig = 1'b0;
    repeat (LAT-1) tick();
    arm(5);
    chk("f_arm_wins", WW'(snap_state), WW'(1));
    repeat (3) tick();
    chk("f_still_pre", WW'(snap_state), WW'(1));

    // srst in the middle of POST
    repeat (5) tick();
    trig();
    repeat (10) tick();
    chk("g_post_state", WW'(snap_state), WW'(3));
    srst = 1'b1;
    tick();
    chk("g_rst_state", WW'(snap_state), WW'(0));
    chk("g_rst_ready", WW'(bif.snap_capture_ready), WW'(0));
    chk("g_rst_ptr", WW'(trig_ptr), WW'(0));
    chk("g_rst_data", WW'(bif.adc_snap_data), WW'(0));
    srst = 1'b0;
    repeat (5) tick();
    chk("g_idle_stays", WW'(snap_state), WW'(0));
    chk("g_idle_ready", WW'(bif.snap_capture_ready), WW'(0));

`ifdef SNAP_LEVEL_TRIG_EN
    // level trigger: |100| does not exceed 100, |-101| does
    trig_sel = 1'b1;
    trig_level = 8'd100;
    use_fixed = 1'b1;
    fixed_word = '0;
    arm(10);
    repeat (15) tick();
    fixed_word[2*8 +: 8] = 8'd100;
    repeat (5) tick();
    chk("h_lvl_100_no_trig", WW'(snap_state), WW'(2));
    fixed_word[2*8 +: 8] = 8'h9B;
    trig_cyc = hist.size();
    tick();
    fixed_word = '0;
    wait_ready("h_lvl_ready_lat");
    chk("h_lvl_ptr", WW'(trig_ptr), WW'(exp_ptr()));
    read_chk("h_lvl_word", 10, 0, 2);
    use_fixed = 1'b0;
    trig_sel = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
